// File: rtl/hazard_sequencer.sv
// Central stall/flush controller for the 5-stage IF/ID/EX/MEM/WB pipeline.
// Resolves the per-cycle hazards into pipeline register enables and flushes.
// The hazards come from the forwarding unit (load-use stall), the EX-stage
// branch resolution and the instruction/data memory handshakes. It also keeps
// stall/flush performance counters and a sticky data-memory timeout flag.
//
// Ports:
//   clk, rstn         clock, asynchronous active-low reset
//   load_use          forwarding-unit load-use stall request
//   temp_wb           forwarding unit sources an operand from WB_temp (monitor only)
//   ex_branch_taken   EX resolved a taken branch/jump
//   imem_ready        fetch data valid this cycle
//   mem_req           MEM-stage instruction is a load/store
//   dmem_ready        data memory completes the access this cycle
//   *_we              pipeline register write enables (combinational)
//   if_id_flush, id_ex_flush, ex_mem_bubble   NOP injection (combinational)
//   wb_temp_we        capture outgoing MEM/WB into WB_temp (combinational)
//   state             00 RUN, 01 LSTALL, 10 DWAIT
//   stall_cnt         saturating count of cycles with pc_we=0
//   flush_cnt         saturating count of taken-branch redirects
//   mem_timeout       sticky: one DWAIT episode lasted DWAIT_MAX cycles
module hazard_sequencer #(
    parameter int unsigned CNT_W     = 32,
    parameter int unsigned DWAIT_MAX = 64
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load_use,
    input  logic             temp_wb,
    input  logic             ex_branch_taken,
    input  logic             imem_ready,
    input  logic             mem_req,
    input  logic             dmem_ready,
    output logic             pc_we,
    output logic             if_id_we,
    output logic             id_ex_we,
    output logic             ex_mem_we,
    output logic             mem_wb_we,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_bubble,
    output logic             wb_temp_we,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             mem_timeout
);

    localparam int unsigned WC_W = $clog2(DWAIT_MAX + 1);

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_LSTALL = 2'b01,
        ST_DWAIT  = 2'b10
    } state_e;

    state_e          state_q;
    state_e          state_d;
    logic [WC_W-1:0] wait_cnt;
    logic            frozen;
    logic            eval_lu;
    logic            eval_imem;
    logic            redirect;

    // temp_wb is observed for debug only and intentionally drives nothing
    logic unused_temp_wb;
    assign unused_temp_wb = temp_wb;

    assign state = state_q;

    // Hazard resolution: freeze > load-use > branch > imem wait > normal
    always_comb begin
        state_d       = ST_RUN;
        pc_we         = 1'b1;
        if_id_we      = 1'b1;
        id_ex_we      = 1'b1;
        ex_mem_we     = 1'b1;
        mem_wb_we     = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        ex_mem_bubble = 1'b0;
        wb_temp_we    = 1'b0;
        redirect      = 1'b0;
        frozen        = mem_req && !dmem_ready;
        eval_lu       = 1'b1;
        eval_imem     = 1'b1;

        // DWAIT ignores mem_req: only dmem_ready ends the episode.
        // LSTALL masks load_use and applies only dmem wait and branch.
        case (state_q)
            ST_DWAIT:  frozen = !dmem_ready;
            ST_LSTALL: begin
                eval_lu   = 1'b0;
                eval_imem = 1'b0;
            end
            default: ;
        endcase

        if (frozen) begin
            pc_we     = 1'b0;
            if_id_we  = 1'b0;
            id_ex_we  = 1'b0;
            ex_mem_we = 1'b0;
            mem_wb_we = 1'b0;
            state_d   = ST_DWAIT;
        end else if (eval_lu && load_use) begin
            pc_we         = 1'b0;
            if_id_we      = 1'b0;
            id_ex_we      = 1'b0;
            ex_mem_bubble = 1'b1;
            wb_temp_we    = 1'b1;
            state_d       = ST_LSTALL;
        end else if (ex_branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            redirect    = 1'b1;
        end else if (eval_imem && !imem_ready) begin
            pc_we       = 1'b0;
            if_id_flush = 1'b1;
        end

        // Reset holds the pipe with NOPs injected, overriding everything
        if (!rstn) begin
            pc_we         = 1'b0;
            if_id_we      = 1'b0;
            id_ex_we      = 1'b0;
            ex_mem_we     = 1'b0;
            mem_wb_we     = 1'b0;
            if_id_flush   = 1'b1;
            id_ex_flush   = 1'b1;
            ex_mem_bubble = 1'b1;
            wb_temp_we    = 1'b0;
            redirect      = 1'b0;
        end
    end

    // State register, performance counters and DWAIT episode timer
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_RUN;
            stall_cnt   <= '0;
            flush_cnt   <= '0;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state_q <= state_d;
            if (!pc_we && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (redirect && (flush_cnt != {CNT_W{1'b1}})) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
            if (frozen && (state_q != ST_DWAIT)) begin
                wait_cnt <= '0;
            end else if (frozen) begin
                if (wait_cnt != WC_W'(DWAIT_MAX)) begin
                    wait_cnt <= wait_cnt + WC_W'(1);
                end
                if (wait_cnt >= WC_W'(DWAIT_MAX - 1)) begin
                    mem_timeout <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed self-checking bench for hazard_sequencer.
module tb_hazard_sequencer;

    localparam int unsigned CNT_W = 32;

    logic             clk;
    logic             rstn;
    logic             load_use;
    logic             temp_wb;
    logic             ex_branch_taken;
    logic             imem_ready;
    logic             mem_req;
    logic             dmem_ready;
    logic             pc_we;
    logic             if_id_we;
    logic             id_ex_we;
    logic             ex_mem_we;
    logic             mem_wb_we;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             ex_mem_bubble;
    logic             wb_temp_we;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic             mem_timeout;

    int checks;
    int errors;

    hazard_sequencer #(.CNT_W(CNT_W), .DWAIT_MAX(64)) dut (
        .clk             (clk),
        .rstn            (rstn),
        .load_use        (load_use),
        .temp_wb         (temp_wb),
        .ex_branch_taken (ex_branch_taken),
        .imem_ready      (imem_ready),
        .mem_req         (mem_req),
        .dmem_ready      (dmem_ready),
        .pc_we           (pc_we),
        .if_id_we        (if_id_we),
        .id_ex_we        (id_ex_we),
        .ex_mem_we       (ex_mem_we),
        .mem_wb_we       (mem_wb_we),
        .if_id_flush     (if_id_flush),
        .id_ex_flush     (id_ex_flush),
        .ex_mem_bubble   (ex_mem_bubble),
        .wb_temp_we      (wb_temp_we),
        .state           (state),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt),
        .mem_timeout     (mem_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // enables packed {pc, if_id, id_ex, ex_mem, mem_wb}; flushes {if_id, id_ex, bubble}
    logic [4:0] we_v;
    logic [2:0] fl_v;
    assign we_v = {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we};
    assign fl_v = {if_id_flush, id_ex_flush, ex_mem_bubble};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        load_use        = 1'b0;
        temp_wb         = 1'b0;
        ex_branch_taken = 1'b0;
        imem_ready      = 1'b1;
        mem_req         = 1'b0;
        dmem_ready      = 1'b0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        idle_inputs();
        tick();
        tick();
        rstn = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rstn   = 1'b0;
        idle_inputs();

        // Reset state
        #3;
        chk("rst_we", 64'(we_v), 64'h00);
        chk("rst_fl", 64'(fl_v), 64'h7);
        chk("rst_wbt", 64'(wb_temp_we), 64'h0);
        chk("rst_state", 64'(state), 64'h0);
        chk("rst_stall", 64'(stall_cnt), 64'h0);
        chk("rst_flush", 64'(flush_cnt), 64'h0);
        chk("rst_tmo", 64'(mem_timeout), 64'h0);
        tick();
        rstn = 1'b1;

        // 1: idle RUN for 10 cycles
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_we", 64'(we_v), 64'h1f);
            chk("idle_fl", 64'(fl_v), 64'h0);
            tick();
        end
        chk("idle_state", 64'(state), 64'h0);
        chk("idle_stall", 64'(stall_cnt), 64'h0);

        // 2: load-use pulse, then one LSTALL cycle
        load_use = 1'b1;
        temp_wb  = 1'b1;
        @(negedge clk);
        chk("lu_we", 64'(we_v), 64'h03);
        chk("lu_fl", 64'(fl_v), 64'h1);
        chk("lu_wbt", 64'(wb_temp_we), 64'h1);
        chk("lu_state", 64'(state), 64'h0);
        tick();
        load_use = 1'b0;
        temp_wb  = 1'b0;
        @(negedge clk);
        chk("ls_state", 64'(state), 64'h1);
        chk("ls_we", 64'(we_v), 64'h1f);
        chk("ls_fl", 64'(fl_v), 64'h0);
        chk("ls_wbt", 64'(wb_temp_we), 64'h0);
        chk("ls_stall", 64'(stall_cnt), 64'h1);
        tick();
        chk("ls_back", 64'(state), 64'h0);

        // 3: dmem wait 3 cycles then release
        do_reset();
        mem_req    = 1'b1;
        dmem_ready = 1'b0;
        @(negedge clk);
        chk("dw0_we", 64'(we_v), 64'h00);
        chk("dw0_state", 64'(state), 64'h0);
        tick();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("dw_we", 64'(we_v), 64'h00);
            chk("dw_fl", 64'(fl_v), 64'h0);
            chk("dw_state", 64'(state), 64'h2);
            tick();
        end
        dmem_ready = 1'b1;
        @(negedge clk);
        chk("dwr_we", 64'(we_v), 64'h1f);
        chk("dwr_state", 64'(state), 64'h2);
        chk("dwr_stall", 64'(stall_cnt), 64'h3);
        tick();
        mem_req = 1'b0;
        chk("dwr_back", 64'(state), 64'h0);
        chk("dwr_stall2", 64'(stall_cnt), 64'h3);

        // 4: branch beats imem wait; then imem wait alone
        do_reset();
        ex_branch_taken = 1'b1;
        imem_ready      = 1'b0;
        @(negedge clk);
        chk("br_we", 64'(we_v), 64'h1f);
        chk("br_fl", 64'(fl_v), 64'h6);
        tick();
        ex_branch_taken = 1'b0;
        chk("br_flush", 64'(flush_cnt), 64'h1);
        chk("br_stall", 64'(stall_cnt), 64'h0);
        @(negedge clk);
        chk("iw_we", 64'(we_v), 64'h0f);
        chk("iw_fl", 64'(fl_v), 64'h4);
        tick();
        imem_ready = 1'b1;
        chk("iw_stall", 64'(stall_cnt), 64'h1);
        chk("iw_flush", 64'(flush_cnt), 64'h1);

        // 5: load_use during dmem wait; bubble issued in release cycle; LSTALL masks load_use
        do_reset();
        load_use   = 1'b1;
        mem_req    = 1'b1;
        dmem_ready = 1'b0;
        @(negedge clk);
        chk("co0_we", 64'(we_v), 64'h00);
        chk("co0_fl", 64'(fl_v), 64'h0);
        chk("co0_wbt", 64'(wb_temp_we), 64'h0);
        tick();
        @(negedge clk);
        chk("co1_state", 64'(state), 64'h2);
        chk("co1_fl", 64'(fl_v), 64'h0);
        tick();
        dmem_ready = 1'b1;
        @(negedge clk);
        chk("cor_we", 64'(we_v), 64'h03);
        chk("cor_fl", 64'(fl_v), 64'h1);
        chk("cor_wbt", 64'(wb_temp_we), 64'h1);
        tick();
        mem_req = 1'b0;
        @(negedge clk);
        chk("col_state", 64'(state), 64'h1);
        chk("col_we", 64'(we_v), 64'h1f);
        chk("col_wbt", 64'(wb_temp_we), 64'h0);
        tick();
        load_use = 1'b0;
        chk("col_back", 64'(state), 64'h0);
        chk("co_stall", 64'(stall_cnt), 64'h3);

        // 5b: branch still honoured in LSTALL
        load_use = 1'b1;
        tick();
        load_use        = 1'b0;
        ex_branch_taken = 1'b1;
        @(negedge clk);
        chk("lsb_state", 64'(state), 64'h1);
        chk("lsb_fl", 64'(fl_v), 64'h6);
        tick();
        ex_branch_taken = 1'b0;
        chk("lsb_flush", 64'(flush_cnt), 64'h1);

        // 6: DWAIT timeout at 64 frozen DWAIT cycles
        do_reset();
        mem_req    = 1'b1;
        dmem_ready = 1'b0;
        tick();
        repeat (63) tick();
        @(negedge clk);
        chk("to_pre", 64'(mem_timeout), 64'h0);
        chk("to_pre_we", 64'(we_v), 64'h00);
        tick();
        @(negedge clk);
        chk("to_set", 64'(mem_timeout), 64'h1);
        chk("to_frozen", 64'(we_v), 64'h00);
        chk("to_stall", 64'(stall_cnt), 64'd65);
        dmem_ready = 1'b1;
        tick();
        mem_req    = 1'b0;
        dmem_ready = 1'b0;
        @(negedge clk);
        chk("to_sticky", 64'(mem_timeout), 64'h1);
        chk("to_state", 64'(state), 64'h0);
        tick();

        // 6b: async reset mid-DWAIT
        mem_req = 1'b1;
        tick();
        tick();
        chk("mid_state", 64'(state), 64'h2);
        #2;
        rstn = 1'b0;
        #1;
        chk("mid_rst_state", 64'(state), 64'h0);
        chk("mid_rst_stall", 64'(stall_cnt), 64'h0);
        chk("mid_rst_tmo", 64'(mem_timeout), 64'h0);
        chk("mid_rst_we", 64'(we_v), 64'h00);
        chk("mid_rst_fl", 64'(fl_v), 64'h7);
        idle_inputs();
        tick();
        rstn = 1'b1;
        @(negedge clk);
        chk("post_we", 64'(we_v), 64'h1f);
        chk("post_fl", 64'(fl_v), 64'h0);
        chk("post_state", 64'(state), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
